// File: rtl/da_dct_pkg.sv
// Shared constants for the DCT distributed-arithmetic row engine: Q2.14 cosines,
// the default half-row coefficient matrix, the LUT-build helper and the FSM states.
package da_dct_pkg;

    localparam int COEF_W   = 16;
    localparam int FRAC_W   = 14;
    localparam int MAT_ROWS = 8;
    localparam int MAT_TAPS = 4;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t C1 = 16'sh3EC5;
    localparam coef_t C2 = 16'sh3B21;
    localparam coef_t C3 = 16'sh3537;
    localparam coef_t C4 = 16'sh2D41;
    localparam coef_t C5 = 16'sh238E;
    localparam coef_t C6 = 16'sh187E;
    localparam coef_t C7 = 16'sh0C7C;

    // Row r is DCT output r: even rows act on x[k]+x[7-k], odd rows on x[k]-x[7-k].
    localparam coef_t COEF [MAT_ROWS][MAT_TAPS] = '{
        '{ C4,  C4,  C4,  C4},
        '{ C1,  C3,  C5,  C7},
        '{ C2,  C6, -C6, -C2},
        '{ C3, -C7, -C1, -C5},
        '{ C4, -C4, -C4,  C4},
        '{ C5, -C1,  C7,  C3},
        '{ C6, -C2,  C2, -C6},
        '{ C7, -C5,  C3, -C1}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } da_state_e;

    // Full-precision subset sum; the caller truncates to its LUT width.
    function automatic int lut_entry(int r, int a, int taps);
        int s;
        s = 0;
        for (int k = 0; k < taps; k++) begin
            if (((a >> k) & 1) == 1 && r < MAT_ROWS && k < MAT_TAPS)
                s += int'(COEF[r][k]);
        end
        return s;
    endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational partial-sum ROM: entry [row][a] is the sum of the row's
// coefficients selected by the bits of a, built at elaboration.
module da_lut
    import da_dct_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int ROWS   = 8,
    parameter int COEF_W = 16,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic        [ROW_W-1:0]  row,
    input  logic        [TAPS-1:0]   a,
    output logic signed [COEF_W-1:0] p
);

    localparam int DEPTH = 2 ** (ROW_W + TAPS);

    logic [COEF_W-1:0] rom [DEPTH];

    // Rows past ROWS are zero-filled so an out-of-range row yields y = 0.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        if ((i >> TAPS) < ROWS) begin : g_used
            assign rom[i] = COEF_W'(lut_entry(i >> TAPS, i & (2 ** TAPS - 1), TAPS));
        end else begin : g_unused
            assign rom[i] = '0;
        end
    end

    assign p = $signed(rom[{row, a}]);

endmodule

// File: rtl/da_row_mac.sv
// Bit-serial DA row engine: one LUT lookup per sample bit plane, shift-accumulated
// with the MSB plane subtracted, giving y = sum_k COEF[row][k] * x[k].
module da_row_mac
    import da_dct_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int ROWS   = 8,
    parameter int DATA_W = 12,
    parameter int COEF_W = da_dct_pkg::COEF_W,
    parameter int ACC_W  = COEF_W + DATA_W + $clog2(TAPS),
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROW_W-1:0]         row,
    input  logic [TAPS*DATA_W-1:0]   x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  y
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    da_state_e                 state_q;
    logic [TAPS*DATA_W-1:0]    xsr_q, xsr_d;
    logic [ROW_W-1:0]          row_q;
    logic [BIT_W-1:0]          bit_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      in_ready_q, out_valid_q;

    logic [TAPS-1:0]           lut_a;
    logic signed [COEF_W-1:0]  lut_p;
    logic signed [ACC_W-1:0]   p_ext, term;

    always_comb begin
        lut_a = '0;
        for (int k = 0; k < TAPS; k++)
            lut_a[k] = xsr_q[k*DATA_W];
    end

    da_lut #(
        .TAPS   (TAPS),
        .ROWS   (ROWS),
        .COEF_W (COEF_W)
    ) u_lut (
        .row (row_q),
        .a   (lut_a),
        .p   (lut_p)
    );

    // Whole-vector shift: bits leaking into a lane's top never reach its LSB
    // within DATA_W steps, so per-lane shifting is unnecessary.
    assign xsr_d = xsr_q >> 1;

    always_comb begin
        p_ext = {{(ACC_W-COEF_W){lut_p[COEF_W-1]}}, lut_p};
        term  = p_ext <<< bit_q;
        acc_d = (bit_q == BIT_LAST) ? acc_q - term : acc_q + term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            xsr_q       <= '0;
            row_q       <= '0;
            bit_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && en) begin
                        xsr_q      <= x;
                        row_q      <= row;
                        bit_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        acc_q <= acc_d;
                        xsr_q <= xsr_d;
                        bit_q <= bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = acc_q;

endmodule

// File: tb/tb_da_row_mac.sv
// Self-checking bench for da_row_mac: directed cases plus random transactions
// compared against an arithmetic bit-plane model of the DA dot product.
module tb_da_row_mac;

    localparam int TAPS   = 4;
    localparam int ROWS   = 8;
    localparam int DATA_W = 12;
    localparam int COEF_W = 16;
    localparam int ACC_W  = COEF_W + DATA_W + $clog2(TAPS);

    localparam int K1 = 16069, K2 = 15137, K3 = 13623, K4 = 11585;
    localparam int K5 = 9102,  K6 = 6270,  K7 = 3196;

    int tbc [8][4] = '{
        '{ K4,  K4,  K4,  K4},
        '{ K1,  K3,  K5,  K7},
        '{ K2,  K6, -K6, -K2},
        '{ K3, -K7, -K1, -K5},
        '{ K4, -K4, -K4,  K4},
        '{ K5, -K1,  K7,  K3},
        '{ K6, -K2,  K2, -K6},
        '{ K7, -K5,  K3, -K1}
    };

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [2:0]                row = '0;
    logic [TAPS*DATA_W-1:0]    x = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic signed [ACC_W-1:0]   y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    da_row_mac #(
        .TAPS   (TAPS),
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row       (row),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Each bit plane selects a coefficient subset whose sum wraps to 16 bits
    // (the LUT width); planes are weighted 2^b, the sign plane negatively.
    function automatic longint model_y(int r, logic [TAPS*DATA_W-1:0] xv);
        longint acc;
        int s;
        logic [15:0] t;
        longint ps;
        acc = 0;
        for (int b = 0; b < DATA_W; b++) begin
            s = 0;
            for (int k = 0; k < TAPS; k++)
                if (xv[k*DATA_W + b]) s += tbc[r][k];
            t  = s[15:0];
            ps = longint'($signed(t)) * (longint'(1) << b);
            acc = (b == DATA_W - 1) ? acc - ps : acc + ps;
        end
        return acc;
    endfunction

    task automatic accept_and_wait(input logic [2:0] r, input logic [TAPS*DATA_W-1:0] xv,
                                   input bit toggle_en, input string tag, output bit seen);
        int  ones;
        bit  busy_ok;
        @(negedge clk);
        en = 1'b1; row = r; x = xv; in_valid = 1'b1;
        check({tag, ":in_ready_idle"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        ones = 0; busy_ok = 1'b1; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            en = toggle_en ? c[0] : 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            row = 3'($urandom);
            x = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            if (en) ones++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) busy_ok = 1'b0;
        end
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0;
        check({tag, ":done_seen"}, longint'(seen), 1);
        check({tag, ":latency_en_edges"}, longint'(ones), longint'(DATA_W));
        check({tag, ":busy_in_ready_low"}, longint'(busy_ok), 1);
    endtask

    task automatic run_txn(input logic [2:0] r, input logic [TAPS*DATA_W-1:0] xv,
                           input bit toggle_en, input int hold, input string tag,
                           output longint yo);
        bit seen;
        bit stable;
        accept_and_wait(r, xv, toggle_en, tag, seen);
        yo = longint'(y);
        check({tag, ":y_model"}, yo, model_y(int'(r), xv));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            x = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            if (!out_valid || longint'(y) != yo || in_ready) stable = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) check({tag, ":done_hold_stable"}, longint'(stable), 1);
        in_valid = 1'b0; en = 1'($urandom_range(0, 1)); out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ":out_valid_drop"}, longint'(out_valid), 0);
        check({tag, ":back_to_idle"}, longint'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0; en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint yv;
        bit     seen;
        logic [2:0]              rr;
        logic [TAPS*DATA_W-1:0]  xr;

        #12;
        check("reset:in_ready", longint'(in_ready), 1);
        check("reset:out_valid", longint'(out_valid), 0);
        check("reset:y", longint'(y), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(3'd0, 48'h000_000_000_001, 1'b0, 0, "c4_unit", yv);
        check("c4_unit:const", yv, 64'h2D41);

        run_txn(3'd2, 48'hFFF_FFF_FFF_FFF, 1'b0, 0, "row2_cancel", yv);
        check("row2_cancel:const", yv, 0);

        run_txn(3'd2, 48'h000_000_001_001, 1'b0, 0, "row2_c2c6", yv);
        check("row2_c2c6:const", yv, 64'h539F);

        run_txn(3'd0, 48'h000_000_800_7FF, 1'b0, 0, "extremes", yv);
        check("extremes:const", yv, -11585);

        run_txn(3'd5, 48'h7FF_800_123_ABC, 1'b0, 10, "hold10", yv);

        run_txn(3'd0, 48'h000_000_800_7FF, 1'b1, 2, "en_toggle", yv);
        check("en_toggle:const", yv, -11585);

        // Reset part-way through RUN (bit counter at 5).
        @(negedge clk);
        row = 3'd1; x = 48'hFFF_7FF_555_AAA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_run:out_valid", longint'(out_valid), 0);
        check("rst_run:y", longint'(y), 0);
        check("rst_run:in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a result waits in DONE.
        accept_and_wait(3'd3, 48'h123_456_789_ABC, 1'b0, "rst_done", seen);
        rst_n = 1'b0;
        #1;
        check("rst_done:out_valid", longint'(out_valid), 0);
        check("rst_done:y", longint'(y), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(3'd7, 48'h0F0_F0F_333_CCC, 1'b0, 1, "post_reset", yv);

        for (int n = 0; n < 24; n++) begin
            rr = 3'($urandom);
            xr = {16'($urandom), 32'($urandom)};
            run_txn(rr, xr, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand", yv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
